// File: rtl/async_fifo_pkg.sv
// Shared Gray/binary helpers and default sizing for the async FIFO pointer blocks.
// Helpers work on a wide zero-extended vector so any pointer width up to PTR_MAX fits.
package async_fifo_pkg;

    localparam int ADDRSIZE_DEF = 4;
    localparam int PTR_MAX      = 32;

    typedef logic [PTR_MAX-1:0] ptr_max_t;

    function automatic ptr_max_t bin2gray(input ptr_max_t b);
        return (b >> 1) ^ b;
    endfunction

    // Zero upper bits leave the MSB-down XOR prefix of the real pointer unchanged.
    function automatic ptr_max_t gray2bin(input ptr_max_t g);
        ptr_max_t b;
        b = '0;
        b[PTR_MAX-1] = g[PTR_MAX-1];
        for (int i = PTR_MAX - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

endpackage

// File: rtl/rptr_empty_lvl_if.sv
// Read-side bus of the async FIFO pointer block; raempty present only with RPTR_EMPTY_AE_EN.
// Handshake: rinc is a pop request, accepted on a rising rclk edge only when rempty is 0 there.
interface rptr_empty_lvl_if #(
    parameter int ADDRSIZE = async_fifo_pkg::ADDRSIZE_DEF
);
    logic                rinc;
    logic [ADDRSIZE:0]   rq2_wptr;
    logic                rclr_err;
    logic [ADDRSIZE-1:0] raddr;
    logic [ADDRSIZE:0]   rptr;
    logic                rempty;
    logic [ADDRSIZE:0]   rlevel;
    logic                runderflow;
`ifdef RPTR_EMPTY_AE_EN
    logic                raempty;

    modport master (
        output rinc, rq2_wptr, rclr_err,
        input  raddr, rptr, rempty, rlevel, runderflow, raempty
    );
    modport slave (
        input  rinc, rq2_wptr, rclr_err,
        output raddr, rptr, rempty, rlevel, runderflow, raempty
    );
`else
    modport master (
        output rinc, rq2_wptr, rclr_err,
        input  raddr, rptr, rempty, rlevel, runderflow
    );
    modport slave (
        input  rinc, rq2_wptr, rclr_err,
        output raddr, rptr, rempty, rlevel, runderflow
    );
`endif
endinterface

// File: rtl/rptr_empty_lvl_gray2bin_conv.sv
// Combinational Gray-to-binary converter of width W.
module gray2bin_conv
    import async_fifo_pkg::*;
#(
    parameter int W = ADDRSIZE_DEF + 1
) (
    input  logic [W-1:0] gray_i,
    output logic [W-1:0] bin_o
);

    assign bin_o = W'(gray2bin(ptr_max_t'(gray_i)));

endmodule

// File: rtl/rptr_empty_lvl.sv
// Read-domain pointer, registered empty flag, occupancy level and sticky underflow.
// Optional almost-empty output enabled by RPTR_EMPTY_AE_EN.
module rptr_empty_lvl
    import async_fifo_pkg::*;
#(
    parameter int ADDRSIZE  = ADDRSIZE_DEF,
    parameter int AE_THRESH = 2
) (
    input  logic             rclk,
    input  logic             rrst_n,
    rptr_empty_lvl_if.slave  bus
);

    localparam int PW = ADDRSIZE + 1;

    // A threshold above the depth would make almost-empty permanently true.
    if (AE_THRESH > (1 << ADDRSIZE)) begin : g_thresh_exceeds_depth
    end

    logic [PW-1:0] rbin_q, rbin_d;
    logic [PW-1:0] rptr_q, rgray_d;
    logic [PW-1:0] rlevel_q, level_d;
    logic [PW-1:0] wbin_s;
    logic          rempty_q, rempty_d;
    logic          runder_q, runder_d;
    logic          pop_ok;

    gray2bin_conv #(.W(PW)) u_wptr_g2b (
        .gray_i (bus.rq2_wptr),
        .bin_o  (wbin_s)
    );

    always_comb begin
        pop_ok   = bus.rinc & ~rempty_q;
        rbin_d   = rbin_q + PW'(pop_ok);
        rgray_d  = PW'(bin2gray(ptr_max_t'(rbin_d)));
        // Compare against the post-pop pointer so the last pop flags empty on the same edge.
        rempty_d = (rgray_d == bus.rq2_wptr);
        level_d  = wbin_s - rbin_d;
        runder_d = (bus.rinc & rempty_q) | (runder_q & ~bus.rclr_err);
    end

    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            rbin_q   <= '0;
            rptr_q   <= '0;
            rempty_q <= 1'b1;
            rlevel_q <= '0;
            runder_q <= 1'b0;
        end else begin
            rbin_q   <= rbin_d;
            rptr_q   <= rgray_d;
            rempty_q <= rempty_d;
            rlevel_q <= level_d;
            runder_q <= runder_d;
        end
    end

    assign bus.raddr      = rbin_q[ADDRSIZE-1:0];
    assign bus.rptr       = rptr_q;
    assign bus.rempty     = rempty_q;
    assign bus.rlevel     = rlevel_q;
    assign bus.runderflow = runder_q;

`ifdef RPTR_EMPTY_AE_EN
    logic raempty_q, raempty_d;

    assign raempty_d = (level_d <= PW'(AE_THRESH));

    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) raempty_q <= 1'b1;
        else         raempty_q <= raempty_d;
    end

    assign bus.raempty = raempty_q;
`endif

endmodule

// File: doc/rptr_empty_lvl.md
Name: rptr_empty_lvl

Overview:
Read-side pointer and empty-flag generator for the asynchronous FIFO. It runs entirely in the read clock domain and is the counterpart of the write-pointer/full block. It takes the write pointer, already Gray-coded and double-synchronized into rclk, and produces:
- the binary RAM read address;
- the Gray read pointer, which is synchronized back to the write side;
- a registered empty flag, an occupancy level and a sticky underflow error.

Parameters:
- ADDRSIZE, 4, RAM address width; FIFO depth = 2**ADDRSIZE; pointers are ADDRSIZE+1 bits.
- AE_THRESH, 2, almost-empty threshold in words; used only when RPTR_EMPTY_AE_EN is defined.

Ports:
- rclk  input  1  read-domain clock
- rrst_n  input  1  asynchronous active-low reset
- rinc  input  1  pop request from the reader
- rq2_wptr  input  ADDRSIZE+1  Gray write pointer, double-synchronized into rclk
- rclr_err  input  1  synchronous clear of runderflow
- raddr  output  ADDRSIZE  RAM read address
- rptr  output  ADDRSIZE+1  Gray read pointer (registered)
- rempty  output  1  FIFO empty (registered)
- rlevel  output  ADDRSIZE+1  registered occupancy, range 0..2**ADDRSIZE
- runderflow  output  1  sticky: a pop was attempted while empty
- raempty  output  1  almost empty; exists only with RPTR_EMPTY_AE_EN

Behaviour:
- Reset, asynchronous on negedge rrst_n:
  - rbin = 0, rptr = 0, raddr = 0.
  - rempty = 1, rlevel = 0, runderflow = 0, raempty = 1.
- Next-state logic:
  - rbinnext = rbin + (rinc & ~rempty), modulo 2**(ADDRSIZE+1).
  - rgraynext = (rbinnext >> 1) ^ rbinnext.
- On every rclk rising edge: rbin <= rbinnext, rptr <= rgraynext.
- raddr = rbin[ADDRSIZE-1:0], driven combinationally from the register, so the address is valid in the same cycle as rptr.
- Empty flag: rempty <= (rgraynext == rq2_wptr).
  - It asserts on the same edge that consumes the last word; there is no extra cycle of latency.
  - It is pessimistic: it deasserts only after the write pointer has crossed the two synchronizer stages.
- Pop with rempty = 1 is ignored: pointers hold and no RAM advance occurs.
- Level calculation:
  - wbin_s = Gray-to-binary of rq2_wptr (XOR prefix from the MSB down).
  - rlevel <= wbin_s - rbinnext, modulo 2**(ADDRSIZE+1).
  - The value is therefore consistent with the next-cycle read pointer.
  - A full FIFO yields 2**ADDRSIZE because the MSBs differ and the lower bits are equal.
- Underflow:
  - rinc & rempty sets runderflow on the next edge.
  - rclr_err clears it on the next edge.
  - If set and clear occur in the same cycle, set wins.
- Wrap-around: rbin rolls from 2**(ADDRSIZE+1)-1 to 0. The pointer MSB toggles each lap through the RAM, and this toggle is what distinguishes full from empty.
- Reset during operation: all state returns immediately to reset values. Any in-flight pop is lost. The write side sees rptr = 0 after synchronization.
- Simultaneous pop and write-pointer change: both are folded into the same registered compare, with no priority logic. The level stays consistent because it is computed from rbinnext.

Optional Feature:
- Macro RPTR_EMPTY_AE_EN.
- Defined:
  - Port raempty exists.
  - raempty <= ((wbin_s - rbinnext) <= AE_THRESH), registered.
  - Reset value is 1.
  - raempty is 1 whenever rempty is 1.
- Undefined: the raempty port and its logic are absent. All other behaviour is identical.

Decomposition:
- Shared package async_fifo_pkg holds:
  - functions bin2gray and gray2bin, parameterized through ADDRSIZE+1 width;
  - the constant for the default ADDRSIZE.
- The write-pointer block is retargeted to use the same functions.
- One sub-module is natural: gray2bin_conv, a combinational converter of width ADDRSIZE+1. It is instantiated once for wbin_s.

Test Plan (all with ADDRSIZE = 4):
1. Reset: assert rrst_n = 0 mid-clock -> immediately rempty = 1, rptr = 0, raddr = 0, rlevel = 0, runderflow = 0.
2. Fill and drain: drive rq2_wptr = 5'b00010 (gray of 3) -> one edge later rempty = 0, rlevel = 3. Then hold rinc for 3 cycles -> raddr goes 0, 1, 2; on the third edge rempty = 1, rptr = 5'b00010, rlevel = 0.
3. Wrap: preload to rbin = 15 with rq2_wptr = gray(17) = 5'b11001; pop -> rptr = 5'b11000, raddr = 0, rlevel = 1.
4. Full level: rbin = 0 and rq2_wptr = 5'b11000 (gray of 16) -> rlevel = 16, rempty = 0.
5. Underflow: with rempty = 1, pulse rinc -> rptr unchanged, runderflow = 1 and held. Pulse rclr_err -> 0. Apply rinc and rclr_err together while empty -> runderflow stays 1.
6. RPTR_EMPTY_AE_EN with AE_THRESH = 2: level 3 -> raempty = 0; one pop -> raempty = 1; pop down to empty -> raempty stays 1 along with rempty.
